dendy_mapper: RTL
=================

// Module: dendy_mapper
// PURPOSE
//  Parametrised cartridge mapper between the CPU/PPU buses and PRG/CHR/VRAM memories.
//  Replaces the fixed PRG address wiring (prga[13:0]) and fixed CHR/VRAM decode of the board top.
//  Modes: NROM, UxROM, CNROM and, optionally, MMC1.
//  Bank registers are written by the CPU at $8000-$FFFF.
//  Outputs are physical PRG/CHR addresses and the 2K VRAM address after nametable mirroring.
// PARAMETERS
//  PRG_AW    17  PRG memory address width; 16K bank count = 2**(PRG_AW-14)
//  CHR_AW    15  CHR memory address width; 8K bank count = 2**(CHR_AW-13), 4K = 2**(CHR_AW-12)
//  MIRROR_V   1  default mirroring (1 = vertical, 0 = horizontal) for NROM/UxROM/CNROM
// PORTS
//  clock        in   1        system clock (clock_25 domain)
//  reset        in   1        synchronous, active-high reset
//  ce           in   1        CPU clock enable; one bus cycle per ce pulse
//  mode         in   2        0 NROM, 1 UxROM, 2 CNROM, 3 MMC1; sampled only during reset
//  cpu_a        in   16       CPU address
//  cpu_o        in   8        CPU write data
//  cpu_w        in   1        CPU write strobe, valid when ce=1
//  chra         in   14       PPU address ($0000-$3EFF)
//  prg_address  out  PRG_AW   physical PRG address for cpu_a >= $8000
//  chr_address  out  CHR_AW   physical CHR address for chra < $2000
//  vrm_address  out  11       physical 2K VRAM address for chra $2000-$3EFF
//  mirror       out  2        0 single-lo, 1 single-hi, 2 vertical, 3 horizontal
// BEHAVIOUR
//  - Register write strobe: wr = ce & cpu_w & cpu_a[15]. Registers update on the clock edge where wr=1.
//  - Address outputs are combinational from registers and inputs (0 cycles of latency).
//  - A write is visible on the first access after the write cycle.
//  - Reset: mode_q<=mode, prg_bank<=0, chr_bank<=0, mirror<=MIRROR_V?2:3.
//    MMC1 state on reset: ctrl<=5'h0C, shift<=5'b10000, last_wr<=0.
//    Reset mid-operation discards any partial MMC1 load.
//  - Bank numbers are truncated to the available bank bits (wrap-around, no error).
//  - NROM: prg_address = cpu_a[14:0] masked to PRG_AW; 16K images mirror $8000/$C000; writes ignored.
//  - UxROM: wr loads prg_bank<=cpu_o.
//    $8000-$BFFF maps to prg_bank; $C000-$FFFF maps to the last bank (all ones).
//  - CNROM: wr loads chr_bank<=cpu_o; chr_address = {chr_bank, chra[12:0]}; PRG as NROM.
//  - Mirroring: vertical gives vrm_address[10]=chra[10]; horizontal gives chra[11].
//    Single-lo forces 0 and single-hi forces 1; vrm_address[9:0]=chra[9:0].
//  - chra >= $3F00 (palette): vrm_address don't-care, handled by the PPU.
// CONFIGURATION
//  DENDY_MMC1_EN defined: mode 3 is MMC1, with serial loader, ctrl/chr0/chr1/prg registers,
//  and 16K/32K PRG and 4K/8K CHR switching.
//   - wr with cpu_o[7]=1: shift<=5'b10000 and ctrl<=ctrl|5'h0C.
//   - Any other wr: shift<={cpu_o[0],shift[4:1]}.
//   - When the marker bit reaches shift[0] (5th write): commit {cpu_o[0],shift[4:1]} to the
//     register selected by cpu_a[14:13], then shift<=5'b10000.
//   - A wr on the ce cycle immediately following another wr (last_wr=1) is ignored
//     (RMW double-write rule).
//   - ctrl[1:0] drives mirror.
//   - ctrl[3:2]: 0/1 = 32K mode (prg[3:1]); 2 = $8000 fixed to first bank, $C000 = prg;
//     3 = $8000 = prg, $C000 fixed to last bank.
//   - ctrl[4]: 0 = 8K CHR (chr0[4:1]); 1 = two 4K banks chr0/chr1 selected by chra[12].
//  DENDY_MMC1_EN undefined: mode 3 behaves as NROM and no MMC1 logic is synthesised.
// STRUCTURE
//  - dendy_mapper_pkg: mode constants (MODE_NROM..MODE_MMC1), mirror codes
//    (MIR_SINGLE_LO..MIR_HORIZ), MMC1 register index constants.
//  - Sub-module mmc1_loader: serial shift register, last_wr tracking, and commit strobe
//    with a 2-bit index and 5-bit data. Instantiated only under DENDY_MMC1_EN.
// TESTING
//  1. UxROM, PRG_AW=17: write $05 at $8000, then read $8123 -> prg_address=$14123.
//     Read $C000 -> $1C000.
//  2. UxROM: write $0B (wraps to bank 3) -> $8000 maps to $0C000.
//     A write while ce=0 leaves prg_bank unchanged.
//  3. CNROM, CHR_AW=15: write $03 -> chra $0010 gives chr_address=$6010.
//     Write $07 -> $6010 (truncation).
//  4. NROM, MIRROR_V=0: chra $2C05 -> vrm_address=$405. Vertical: chra $2405 -> $405,
//     and $2805 -> $005.
//  5. MMC1: five serial writes of data 5'b01110 to $8000 -> ctrl=$0E, mirror=2.
//     A following write to $E000 of 5'b00010 gives $8000 -> $08000 and $C000 -> $1C000.
//     A back-to-back second wr is ignored.
//  6. MMC1: assert reset after 3 of 5 serial writes, then do 5 new writes.
//     Only the new 5 writes commit; ctrl is back at $0C after reset.

Source files
------------

// File: rtl/dendy_mapper_pkg.sv
// Shared constants for the Dendy cartridge mapper: mode and mirroring codes,
// MMC1 register indices and the nametable A10 selection helper.
package dendy_mapper_pkg;

    typedef enum logic [1:0] {
        MODE_NROM  = 2'd0,
        MODE_UXROM = 2'd1,
        MODE_CNROM = 2'd2,
        MODE_MMC1  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        MIR_SINGLE_LO = 2'd0,
        MIR_SINGLE_HI = 2'd1,
        MIR_VERT      = 2'd2,
        MIR_HORIZ     = 2'd3
    } mirror_e;

    localparam logic [1:0] MMC1_REG_CTRL = 2'd0;
    localparam logic [1:0] MMC1_REG_CHR0 = 2'd1;
    localparam logic [1:0] MMC1_REG_CHR1 = 2'd2;
    localparam logic [1:0] MMC1_REG_PRG  = 2'd3;

    localparam logic [4:0] MMC1_CTRL_RESET = 5'h0C;
    localparam logic [4:0] MMC1_SHIFT_INIT = 5'b10000;

    // Physical VRAM A10 for a given mirroring mode and the PPU's A10/A11.
    function automatic logic vram_a10(input mirror_e m, input logic a10, input logic a11);
        logic b;
        case (m)
            MIR_SINGLE_LO: b = 1'b0;
            MIR_SINGLE_HI: b = 1'b1;
            MIR_VERT:      b = a10;
            MIR_HORIZ:     b = a11;
            default:       b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dendy_mapper_mmc1_loader.sv
// MMC1 serial loader: 5-bit shift register with marker bit, consecutive-write
// suppression, and a commit strobe carrying the target index and data.
module mmc1_loader
    import dendy_mapper_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       wr,
    input  logic [1:0] sel,
    input  logic       bit_reset,
    input  logic       bit_data,
    output logic       commit,
    output logic       clear,
    output logic [1:0] commit_idx,
    output logic [4:0] commit_data
);

    logic [4:0] shift_r;
    logic       last_wr_r;
    logic       accept_s;

    // Decode an accepted write into either a loader clear or a final-bit commit.
    always_comb begin
        accept_s    = wr & ~last_wr_r;
        clear       = accept_s & bit_reset;
        commit      = accept_s & ~bit_reset & shift_r[0];
        commit_idx  = sel;
        commit_data = {bit_data, shift_r[4:1]};
    end

    // Shift register and last-write tracking; the marker bit reaching bit 0 ends a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r   <= MMC1_SHIFT_INIT;
            last_wr_r <= 1'b0;
        end else if (ce) begin
            last_wr_r <= wr;
            if (accept_s) begin
                if (bit_reset || shift_r[0]) begin
                    shift_r <= MMC1_SHIFT_INIT;
                end else begin
                    shift_r <= {bit_data, shift_r[4:1]};
                end
            end else begin
                shift_r <= shift_r;
            end
        end else begin
            shift_r   <= shift_r;
            last_wr_r <= last_wr_r;
        end
    end

endmodule

// File: rtl/dendy_mapper.sv
// Cartridge mapper (NROM/UxROM/CNROM, plus MMC1 when DENDY_MMC1_EN is defined):
// bank registers written at $8000-$FFFF, combinational PRG/CHR/VRAM address mapping.
module dendy_mapper
    import dendy_mapper_pkg::*;
#(
    parameter int PRG_AW   = 17,
    parameter int CHR_AW   = 15,
    parameter bit MIRROR_V = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic [15:0]       cpu_a,
    input  logic [7:0]        cpu_o,
    input  logic              cpu_w,
    input  logic [13:0]       chra,
    output logic [PRG_AW-1:0] prg_address,
    output logic [CHR_AW-1:0] chr_address,
    output logic [10:0]       vrm_address,
    output logic [1:0]        mirror
);

    mode_e      mode_r;
    logic [7:0] prg_bank_r;
    logic [7:0] chr_bank_r;
    mirror_e    mirror_r;
    mirror_e    mirror_s;
    logic       wr_s;

    // Addresses are built 32 bits wide so truncation to PRG_AW/CHR_AW wraps bank numbers.
    logic [31:0] prg_bank16_s;
    logic [31:0] prg_full_s;
    logic [31:0] chr_full_s;
    logic        unused_s;

    assign wr_s = ce & cpu_w & cpu_a[15];

`ifdef DENDY_MMC1_EN
    logic [4:0] ctrl_r;
    logic [4:0] chr0_r;
    logic [4:0] chr1_r;
    logic [4:0] prg_r;
    logic       ld_commit_s;
    logic       ld_clear_s;
    logic [1:0] ld_idx_s;
    logic [4:0] ld_data_s;

    mmc1_loader u_loader (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .wr          (wr_s & (mode_r == MODE_MMC1)),
        .sel         (cpu_a[14:13]),
        .bit_reset   (cpu_o[7]),
        .bit_data    (cpu_o[0]),
        .commit      (ld_commit_s),
        .clear       (ld_clear_s),
        .commit_idx  (ld_idx_s),
        .commit_data (ld_data_s)
    );

    // MMC1 register file, loaded by the serial loader's commit strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_r <= MMC1_CTRL_RESET;
            chr0_r <= 5'd0;
            chr1_r <= 5'd0;
            prg_r  <= 5'd0;
        end else if (ld_clear_s) begin
            ctrl_r <= ctrl_r | MMC1_CTRL_RESET;
        end else if (ld_commit_s) begin
            case (ld_idx_s)
                MMC1_REG_CTRL: ctrl_r <= ld_data_s;
                MMC1_REG_CHR0: chr0_r <= ld_data_s;
                MMC1_REG_CHR1: chr1_r <= ld_data_s;
                MMC1_REG_PRG:  prg_r  <= ld_data_s;
                default:       prg_r  <= prg_r;
            endcase
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    assign unused_s = ^{chra[13], prg_full_s, chr_full_s, prg_r[4]};
`else
    assign unused_s = ^{chra[13], prg_full_s, chr_full_s};
`endif

    // Discrete-mapper registers; mode is latched only while reset is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r     <= mode_e'(mode);
            prg_bank_r <= 8'd0;
            chr_bank_r <= 8'd0;
            mirror_r   <= MIRROR_V ? MIR_VERT : MIR_HORIZ;
        end else if (wr_s) begin
            case (mode_r)
                MODE_UXROM: prg_bank_r <= cpu_o;
                MODE_CNROM: chr_bank_r <= cpu_o;
                default:    prg_bank_r <= prg_bank_r;
            endcase
        end else begin
            prg_bank_r <= prg_bank_r;
        end
    end

    // PRG mapping: NROM passes A14:0, UxROM fixes $C000 to the last 16K bank.
    always_comb begin
        prg_bank16_s = 32'd0;
        prg_full_s   = {17'd0, cpu_a[14:0]};
        case (mode_r)
            MODE_UXROM: begin
                prg_bank16_s = cpu_a[14] ? 32'hFFFF_FFFF : {24'd0, prg_bank_r};
                prg_full_s   = {prg_bank16_s[17:0], cpu_a[13:0]};
            end
`ifdef DENDY_MMC1_EN
            MODE_MMC1: begin
                case (ctrl_r[3:2])
                    2'd2: begin
                        prg_bank16_s = cpu_a[14] ? {28'd0, prg_r[3:0]} : 32'd0;
                        prg_full_s   = {prg_bank16_s[17:0], cpu_a[13:0]};
                    end
                    2'd3: begin
                        prg_bank16_s = cpu_a[14] ? 32'hFFFF_FFFF : {28'd0, prg_r[3:0]};
                        prg_full_s   = {prg_bank16_s[17:0], cpu_a[13:0]};
                    end
                    default: prg_full_s = {14'd0, prg_r[3:1], cpu_a[14:0]};
                endcase
            end
`endif
            default: prg_full_s = {17'd0, cpu_a[14:0]};
        endcase
    end

    // CHR mapping: fixed 8K except CNROM bank and MMC1 4K/8K switching.
    always_comb begin
        chr_full_s = {19'd0, chra[12:0]};
        case (mode_r)
            MODE_CNROM: chr_full_s = {11'd0, chr_bank_r, chra[12:0]};
`ifdef DENDY_MMC1_EN
            MODE_MMC1: begin
                if (ctrl_r[4]) begin
                    chr_full_s = {15'd0, (chra[12] ? chr1_r : chr0_r), chra[11:0]};
                end else begin
                    chr_full_s = {15'd0, chr0_r[4:1], chra[12:0]};
                end
            end
`endif
            default: chr_full_s = {19'd0, chra[12:0]};
        endcase
    end

    // Effective mirroring comes from MMC1 ctrl when active, otherwise the board default.
    always_comb begin
`ifdef DENDY_MMC1_EN
        if (mode_r == MODE_MMC1) begin
            mirror_s = mirror_e'(ctrl_r[1:0]);
        end else begin
            mirror_s = mirror_r;
        end
`else
        mirror_s = mirror_r;
`endif
    end

    assign prg_address = prg_full_s[PRG_AW-1:0];
    assign chr_address = chr_full_s[CHR_AW-1:0];
    assign mirror      = mirror_s;
    assign vrm_address = {vram_a10(mirror_s, chra[10], chra[11]), chra[9:0]};

endmodule
